// File: rtl/aes_chain_ctrl_pkg.sv
// Shared definitions for the AES chaining controller and the external input mux:
// block width, mode encodings, FSM state encoding and the mode decode helper.
package aes_chain_ctrl_pkg;

    localparam int unsigned BLOCK_W = 128;

    typedef enum logic [2:0] {
        MODE_ECB = 3'd0,
        MODE_CBC = 3'd1,
        MODE_CFB = 3'd2,
        MODE_OFB = 3'd3,
        MODE_CTR = 3'd4
    } aes_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } aes_state_e;

    // Unassigned encodings fall back to ECB so the mux never sees an illegal mode.
    function automatic aes_mode_e decode_mode(input logic [2:0] raw);
        aes_mode_e m;
        case (raw)
            3'd1:    m = MODE_CBC;
            3'd2:    m = MODE_CFB;
            3'd3:    m = MODE_OFB;
            3'd4:    m = MODE_CTR;
            default: m = MODE_ECB;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/aes_chain_ctrl_if.sv
// Block-level bus of the AES chaining controller: plaintext/ciphertext handshakes,
// AES core launch/return and the chaining registers exported to the input mux.
interface aes_chain_ctrl_if;
    import aes_chain_ctrl_pkg::*;

    logic [2:0]         mode;
    logic [BLOCK_W-1:0] iv;
    logic               load_iv;
    logic               pt_valid;
    logic               pt_ready;
    logic [BLOCK_W-1:0] plaintext;
    logic [BLOCK_W-1:0] pt_q;
    logic [BLOCK_W-1:0] feedback;
    logic [BLOCK_W-1:0] ctr;
    logic               core_start;
    logic               core_done;
    logic [BLOCK_W-1:0] core_out;
    logic               ct_valid;
    logic               ct_ready;
    logic [BLOCK_W-1:0] ciphertext;

    modport slave (
        input  mode, iv, load_iv, pt_valid, plaintext, core_done, core_out, ct_ready,
        output pt_ready, pt_q, feedback, ctr, core_start, ct_valid, ciphertext
    );

    modport master (
        output mode, iv, load_iv, pt_valid, plaintext, core_done, core_out, ct_ready,
        input  pt_ready, pt_q, feedback, ctr, core_start, ct_valid, ciphertext
    );

endinterface

// File: rtl/aes_chain_ctrl_ctr_inc.sv
// Counter-mode incrementer: adds one to the low CTR_WIDTH bits of a 128-bit block,
// wrapping silently, and passes the upper bits through untouched.
module aes_ctr_inc #(
    parameter int CTR_WIDTH = 128
) (
    input  logic [127:0] ctr_in,
    output logic [127:0] ctr_out
);

    logic [CTR_WIDTH-1:0] low_s;

    assign low_s = ctr_in[CTR_WIDTH-1:0] + CTR_WIDTH'(1'b1);

    generate
        if (CTR_WIDTH >= 128) begin : g_full
            assign ctr_out = low_s;
        end else begin : g_part
            assign ctr_out = {ctr_in[127:CTR_WIDTH], low_s};
        end
    endgenerate

endmodule

// File: rtl/aes_chain_ctrl.sv
// AES block-chaining controller: accepts one plaintext block, launches the AES core,
// applies the ECB/CBC/CFB/OFB/CTR output and feedback rules, presents the ciphertext.
module aes_chain_ctrl
    import aes_chain_ctrl_pkg::*;
#(
    parameter int CTR_WIDTH = 128
) (
    input logic             clk,
    input logic             rst_n,
    aes_chain_ctrl_if.slave bus
);

    aes_state_e         state_r;
    aes_mode_e          mode_r;
    logic [BLOCK_W-1:0] pt_r;
    logic [BLOCK_W-1:0] feedback_r;
    logic [BLOCK_W-1:0] ctr_r;
    logic [BLOCK_W-1:0] ct_r;
    logic               pt_ready_r;
    logic               core_start_r;
    logic               ct_valid_r;

    logic [BLOCK_W-1:0] ct_next_s;
    logic [BLOCK_W-1:0] fb_next_s;
    logic               ctr_upd_s;
    logic [BLOCK_W-1:0] ctr_inc_s;

    aes_ctr_inc #(
        .CTR_WIDTH (CTR_WIDTH)
    ) u_ctr_inc (
        .ctr_in  (ctr_r),
        .ctr_out (ctr_inc_s)
    );

    // Ciphertext and chaining-state update for the block in flight
    always_comb begin
        ct_next_s = bus.core_out;
        fb_next_s = feedback_r;
        ctr_upd_s = 1'b0;
        case (mode_r)
            MODE_ECB: begin
                ct_next_s = bus.core_out;
            end
            MODE_CBC: begin
                ct_next_s = bus.core_out;
                fb_next_s = bus.core_out;
            end
            MODE_CFB: begin
                ct_next_s = pt_r ^ bus.core_out;
                fb_next_s = pt_r ^ bus.core_out;
            end
            MODE_OFB: begin
                ct_next_s = pt_r ^ bus.core_out;
                fb_next_s = bus.core_out;
            end
            MODE_CTR: begin
                ct_next_s = pt_r ^ bus.core_out;
                ctr_upd_s = 1'b1;
            end
            default: begin
                ct_next_s = bus.core_out;
            end
        endcase
    end

    // Block sequencing FSM with registered handshake and chaining registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            mode_r       <= MODE_ECB;
            pt_r         <= 128'd0;
            feedback_r   <= 128'd0;
            ctr_r        <= 128'd0;
            ct_r         <= 128'd0;
            pt_ready_r   <= 1'b1;
            core_start_r <= 1'b0;
            ct_valid_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // iv lands in the same edge as acceptance, so the mux sees it in START
                    if (bus.load_iv) begin
                        feedback_r <= bus.iv;
                        ctr_r      <= bus.iv;
                    end
                    if (bus.pt_valid) begin
                        pt_r         <= bus.plaintext;
                        mode_r       <= decode_mode(bus.mode);
                        pt_ready_r   <= 1'b0;
                        core_start_r <= 1'b1;
                        state_r      <= ST_START;
                    end
                end
                ST_START: begin
                    core_start_r <= 1'b0;
                    state_r      <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.core_done) begin
                        ct_r       <= ct_next_s;
                        feedback_r <= fb_next_s;
                        if (ctr_upd_s) begin
                            ctr_r <= ctr_inc_s;
                        end
                        ct_valid_r <= 1'b1;
                        state_r    <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (bus.ct_ready) begin
                        ct_valid_r <= 1'b0;
                        pt_ready_r <= 1'b1;
                        state_r    <= ST_IDLE;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    pt_ready_r   <= 1'b1;
                    core_start_r <= 1'b0;
                    ct_valid_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pt_ready   = pt_ready_r;
    assign bus.pt_q       = pt_r;
    assign bus.feedback   = feedback_r;
    assign bus.ctr        = ctr_r;
    assign bus.core_start = core_start_r;
    assign bus.ct_valid   = ct_valid_r;
    assign bus.ciphertext = ct_r;

endmodule

// File: tb/tb_aes_chain_ctrl.sv
// Self-checking bench for aes_chain_ctrl: stub AES core (~x after 10 cycles), a
// mode-level reference model, directed scenarios and a randomized block stream.
module tb_aes_chain_ctrl;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    aes_chain_ctrl_if bus ();

    aes_chain_ctrl #(
        .CTR_WIDTH (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference chaining state kept at the mode-equation level
    logic [127:0] m_fb;
    logic [127:0] m_ctr;
    logic [2:0]   cur_mode;

    // Stub core and external input mux
    int           stub_cnt;
    logic [127:0] stub_in;

    always @(posedge clk) begin
        bus.core_done <= 1'b0;
        if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) begin
                bus.core_done <= 1'b1;
                bus.core_out  <= ~stub_in;
            end
        end
        if (bus.core_start === 1'b1) begin
            stub_cnt <= 9;
            case (cur_mode)
                3'd1:       stub_in <= bus.pt_q ^ bus.feedback;
                3'd2, 3'd3: stub_in <= bus.feedback;
                3'd4:       stub_in <= bus.ctr;
                default:    stub_in <= bus.pt_q;
            endcase
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // E(x) = ~x; chaining rules written directly from the mode definitions
    function automatic logic [127:0] model_step(input logic [2:0] md, input logic [127:0] pt);
        logic [127:0] ct;
        logic [127:0] o;
        case (md)
            3'd1: begin ct = ~(pt ^ m_fb); m_fb = ct; end
            3'd2: begin ct = pt ^ ~m_fb;   m_fb = ct; end
            3'd3: begin o = ~m_fb; ct = pt ^ o; m_fb = o; end
            3'd4: begin ct = pt ^ ~m_ctr; m_ctr[31:0] = m_ctr[31:0] + 32'd1; end
            default: ct = ~pt;
        endcase
        return ct;
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_pt_q"}, bus.pt_q, 128'd0);
        check({tag, "_feedback"}, bus.feedback, 128'd0);
        check({tag, "_ctr"}, bus.ctr, 128'd0);
        check({tag, "_ciphertext"}, bus.ciphertext, 128'd0);
        check({tag, "_core_start"}, {127'd0, bus.core_start}, 128'd0);
        check({tag, "_ct_valid"}, {127'd0, bus.ct_valid}, 128'd0);
    endtask

    task automatic do_load_iv(input logic [127:0] v);
        @(negedge clk);
        bus.load_iv = 1'b1;
        bus.iv      = v;
        @(negedge clk);
        bus.load_iv = 1'b0;
        m_fb  = v;
        m_ctr = v;
        check("load_iv_feedback", bus.feedback, v);
        check("load_iv_ctr", bus.ctr, v);
    endtask

    // One full block; wait_iv_lat >= 0 pulses load_iv with ivw while the core is busy
    task automatic run_block(input logic [2:0] md, input logic [127:0] pt, input bit with_iv,
                             input logic [127:0] ivv, input int hold, input int wait_iv_lat,
                             input logic [127:0] ivw, output logic [127:0] got);
        logic [127:0] exp;
        int lat;
        bit seen;
        @(negedge clk);
        check("pt_ready_idle", {127'd0, bus.pt_ready}, 128'd1);
        bus.mode      = md;
        bus.plaintext = pt;
        bus.pt_valid  = 1'b1;
        bus.load_iv   = with_iv;
        bus.iv        = ivv;
        cur_mode      = md;
        if (with_iv) begin
            m_fb  = ivv;
            m_ctr = ivv;
        end
        exp = model_step(md, pt);
        @(posedge clk);
        #1;
        bus.pt_valid = 1'b0;
        bus.load_iv  = 1'b0;
        bus.mode     = 3'($urandom_range(7, 0));
        check("core_start_pulse", {127'd0, bus.core_start}, 128'd1);
        check("pt_ready_busy", {127'd0, bus.pt_ready}, 128'd0);
        @(posedge clk);
        #1;
        check("core_start_one_cycle", {127'd0, bus.core_start}, 128'd0);
        lat  = 2;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (lat == wait_iv_lat) begin
                bus.load_iv = 1'b1;
                bus.iv      = ivw;
            end else begin
                bus.load_iv = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
            if (bus.ct_valid === 1'b1) seen = 1'b1;
        end
        bus.load_iv = 1'b0;
        check("ct_valid_seen", {127'd0, seen}, 128'd1);
        check("latency", 128'(lat), 128'd12);
        check("ciphertext", bus.ciphertext, exp);
        got = bus.ciphertext;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            bus.pt_valid  = 1'b1;
            bus.plaintext = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
            check("hold_ct_valid", {127'd0, bus.ct_valid}, 128'd1);
            check("hold_ciphertext", bus.ciphertext, exp);
            check("hold_pt_ready", {127'd0, bus.pt_ready}, 128'd0);
        end
        @(negedge clk);
        bus.pt_valid = 1'b0;
        bus.ct_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.ct_ready = 1'b0;
        check("ct_valid_drop", {127'd0, bus.ct_valid}, 128'd0);
        check("pt_ready_back", {127'd0, bus.pt_ready}, 128'd1);
        check("pt_q_kept", bus.pt_q, pt);
        check("feedback_after", bus.feedback, m_fb);
        check("ctr_after", bus.ctr, m_ctr);
    endtask

    initial begin
        logic [127:0] got;
        logic [127:0] ct1;
        logic [127:0] iv_a;
        logic [127:0] iv_b;
        bit seen;
        n_tests       = 0;
        n_fail        = 0;
        m_fb          = 128'd0;
        m_ctr         = 128'd0;
        cur_mode      = 3'd0;
        rst_n         = 1'b0;
        bus.mode      = 3'd0;
        bus.iv        = 128'd0;
        bus.load_iv   = 1'b0;
        bus.pt_valid  = 1'b0;
        bus.plaintext = 128'd0;
        bus.ct_ready  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_state("reset");
        check("reset_pt_ready", {127'd0, bus.pt_ready}, 128'd1);

        // ECB directed block
        run_block(3'd0, 128'h000102030405060708090A0B0C0D0E0F, 1'b0, 128'd0, 0, -1, 128'd0, got);
        check("ecb_const", got, 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0);

        // CBC two blocks from iv 0x11..11
        do_load_iv({16{8'h11}});
        run_block(3'd1, 128'd0, 1'b0, 128'd0, 0, -1, 128'd0, ct1);
        check("cbc_ct1", ct1, ~{16{8'h11}});
        run_block(3'd1, 128'd0, 1'b0, 128'd0, 0, -1, 128'd0, got);
        check("cbc_ct2", got, {16{8'h11}});

        // CTR low-word wrap with upper bits preserved
        do_load_iv({96'h0123456789ABCDEFDEADBEEF, 32'hFFFFFFFF});
        run_block(3'd4, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 128'd0, 0, -1, 128'd0, got);
        check("ctr_wrap", bus.ctr, {96'h0123456789ABCDEFDEADBEEF, 32'h00000000});

        // Back-pressure in OUT with pt_valid noise
        run_block(3'd3, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 128'd0, 5, -1, 128'd0, got);

        // Reset while waiting for the core; the late core_done must be ignored
        @(negedge clk);
        bus.mode      = 3'd0;
        bus.plaintext = {$urandom, $urandom, $urandom, $urandom};
        bus.pt_valid  = 1'b1;
        cur_mode      = 3'd0;
        @(posedge clk);
        #1;
        bus.pt_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_state("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        m_fb  = 128'd0;
        m_ctr = 128'd0;
        seen  = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (bus.ct_valid !== 1'b0) seen = 1'b1;
        end
        check("late_done_no_ct_valid", {127'd0, seen}, 128'd0);
        check_reset_state("after_late_done");
        check("after_late_done_pt_ready", {127'd0, bus.pt_ready}, 128'd1);

        // load_iv while busy is ignored; load_iv with acceptance takes effect
        iv_a = {$urandom, $urandom, $urandom, $urandom};
        iv_b = {$urandom, $urandom, $urandom, $urandom};
        do_load_iv(iv_a);
        run_block(3'd0, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 128'd0, 0, 5, iv_b, got);
        check("wait_iv_ignored", bus.feedback, iv_a);
        run_block(3'd1, 128'd0, 1'b1, iv_b, 0, -1, 128'd0, got);
        check("iv_with_accept", got, ~iv_b);

        // Randomized block stream
        for (int n = 0; n < 20; n++) begin
            run_block(3'($urandom_range(7, 0)), {$urandom, $urandom, $urandom, $urandom},
                      ($urandom_range(3, 0) == 0), {$urandom, $urandom, $urandom, $urandom},
                      int'($urandom_range(3, 0)), -1, 128'd0, got);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_chain_ctrl.md
AES_CHAIN_CTRL -- requirements
Module: aes_chain_ctrl

Interface
REQ-001 SHALL have parameter: CTR_WIDTH, default 128, number of low counter bits incremented per block (1..128).
REQ-002 SHALL have ports (name direction width meaning):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  3  0 ECB, 1 CBC, 2 CFB, 3 OFB, 4 CTR; others treated as ECB.
- iv  in  128  initial vector / initial counter.
- load_iv  in  1  load iv into feedback and counter registers.
- pt_valid  in  1  plaintext block offered.
- pt_ready  out  1  plaintext block accepted when both high.
- plaintext  in  128  input block.
- pt_q  out  128  registered plaintext to the input mux.
- feedback  out  128  chaining register to the input mux.
- ctr  out  128  counter register to the input mux.
- core_start  out  1  one-cycle pulse launching the AES core.
- core_done  in  1  one-cycle pulse, core_out valid.
- core_out  in  128  AES core result.
- ct_valid  out  1  ciphertext block valid.
- ct_ready  in  1  downstream accepts when both high.
- ciphertext  out  128  output block.

Function
REQ-003 SHALL implement FSM states IDLE, START, WAIT, OUT.
REQ-004 IDLE: pt_ready=1; on pt_valid, SHALL latch plaintext into pt_q and mode into mode_q, go to START.
REQ-005 START: SHALL assert core_start for exactly one cycle, go to WAIT.
REQ-006 WAIT: on core_done, SHALL register ciphertext, update chaining state (REQ-008), go to OUT; core_done outside WAIT SHALL be ignored.
REQ-007 OUT: ct_valid=1, ciphertext stable until ct_ready; on ct_ready go to IDLE.
REQ-008 Per mode_q, on core_done: ECB ct=core_out, no update; CBC ct=core_out, feedback<=ct; CFB ct=pt_q^core_out, feedback<=ct; OFB ct=pt_q^core_out, feedback<=core_out; CTR ct=pt_q^core_out, ctr low CTR_WIDTH bits +1 modulo 2^CTR_WIDTH, upper bits unchanged.
REQ-009 load_iv SHALL load feedback<=iv and ctr<=iv only in IDLE; if load_iv and pt_valid coincide in IDLE, iv loads first and the accepted block uses the new iv.
REQ-010 load_iv outside IDLE SHALL be ignored.
REQ-011 mode changes after acceptance SHALL NOT affect the in-flight block.
REQ-012 Latency: accept at cycle T, core_start at T+1, ct_valid the cycle after core_done.
REQ-013 pt_ready SHALL be 0 in START, WAIT, OUT (one block in flight).
REQ-014 Counter at all-ones (low CTR_WIDTH bits) SHALL wrap to zero without flag.

Reset
REQ-015 rst_n low SHALL asynchronously force IDLE, pt_q/feedback/ctr/ciphertext=0, core_start=0, ct_valid=0; pt_ready=1 after release.
REQ-016 Reset mid-block SHALL discard the block; a later core_done SHALL be ignored.

Structure
REQ-017 Mode encodings (MODE_ECB..MODE_CTR) and FSM state encoding SHALL live in a shared aes package used also by the input mux.
REQ-018 One sub-module SHALL be natural: aes_ctr_inc (parameterised CTR_WIDTH incrementer).

Verification
Stub core: returns ~aes_in 10 cycles after core_start.
REQ-019 ECB: pt=0x00..0F -> ciphertext=~0x00..0F, ct_valid 12 cycles after acceptance.
REQ-020 CBC two blocks, iv=0x11..11, pt=0 twice -> ct1=~iv, ct2=~(0^ct1)=iv.
REQ-021 CTR, CTR_WIDTH=32, iv low word 0xFFFFFFFF -> after one block ctr low word 0x00000000, upper 96 bits unchanged.
REQ-022 ct_ready held low 5 cycles in OUT -> ciphertext stable, pt_ready=0, pt_valid ignored.
REQ-023 rst_n low during WAIT, stub core_done arrives later -> outputs remain reset, no ct_valid.
REQ-024 load_iv during WAIT with new iv -> feedback unchanged; same load in IDLE with pt_valid -> block uses new iv.
